// File: rtl/npu_pkg.sv
// npu_pkg: class codes, overlay colour constants and FSM states shared by the overlay decoder
package npu_pkg;
  typedef enum logic [2:0] {
    CLS_DOT    = 3'd0,
    CLS_CIRCLE = 3'd1,
    CLS_X      = 3'd2,
    CLS_CROSS  = 3'd3,
    CLS_BG     = 3'd4,
    CLS_OTHER  = 3'd5
  } cls_t;
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  localparam logic [23:0] COL_DOT    = 24'hFFFF00;
  localparam logic [23:0] COL_CIRCLE = 24'h00FF00;
  localparam logic [23:0] COL_X      = 24'h0000FF;
  localparam logic [23:0] COL_CROSS  = 24'hFF0000;
  localparam logic [1:0]  BG_PREFIX  = 2'b11;
endpackage

// File: rtl/overlay_decoder_if.sv
// overlay_decoder_if: pixel stream in, per-pixel class out, frame-summary handshake; master drives pixels/rep_ready, slave is the decoder
interface overlay_decoder_if #(parameter int COUNT_W = 20);
  import npu_pkg::*;
  logic pix_valid;
  logic pix_sof;
  logic pix_eof;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic cls_valid;
  cls_t cls_out;
  logic [7:0] gray_out;
  logic rep_valid;
  logic rep_ready;
  logic [COUNT_W-1:0] rep_cnt0;
  logic [COUNT_W-1:0] rep_cnt1;
  logic [COUNT_W-1:0] rep_cnt2;
  logic [COUNT_W-1:0] rep_cnt3;
  cls_t rep_dom;
  logic err_sync;
  logic err_overrun;
  modport master (
    output pix_valid, pix_sof, pix_eof, pix_r, pix_g, pix_b, rep_ready,
    input  cls_valid, cls_out, gray_out, rep_valid, rep_cnt0, rep_cnt1, rep_cnt2, rep_cnt3,
           rep_dom, err_sync, err_overrun
  );
  modport slave (
    input  pix_valid, pix_sof, pix_eof, pix_r, pix_g, pix_b, rep_ready,
    output cls_valid, cls_out, gray_out, rep_valid, rep_cnt0, rep_cnt1, rep_cnt2, rep_cnt3,
           rep_dom, err_sync, err_overrun
  );
endinterface

// File: rtl/overlay_pixel_classify.sv
// overlay_pixel_classify: combinational rgb -> class code and recovered gray (ports r, g, b in; cls, gray out)
module overlay_pixel_classify
  import npu_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output cls_t       cls,
  output logic [7:0] gray
);
  logic [23:0] rgb;
  assign rgb = {r, g, b};
  always_comb begin
    cls = rgb == COL_DOT    ? CLS_DOT    :
          rgb == COL_CIRCLE ? CLS_CIRCLE :
          rgb == COL_X      ? CLS_X      :
          rgb == COL_CROSS  ? CLS_CROSS  :
          (r == g && g == b && r[7:6] == BG_PREFIX) ? CLS_BG : CLS_OTHER;
    gray = cls == CLS_BG ? {r[5:0], 2'b00} : 8'h00;
  end
endmodule

// File: rtl/overlay_decoder.sv
// overlay_decoder: classifies overlay pixels, counts symbols per frame and offers a summary (ports clk, rst_n, bus slave; OVERLAY_DECODER_GRAY_EN enables gray_out)
module overlay_decoder
  import npu_pkg::*;
#(
  parameter int COUNT_W = 20
) (
  input logic clk,
  input logic rst_n,
  overlay_decoder_if.slave bus
);
  cls_t pix_cls;
  cls_t dom;
  logic [7:0] pix_gray;
  state_t state;
  state_t state_nxt;
  logic take;
  logic load_nxt;
  logic load_pend;
  logic sync_nxt;
  logic [COUNT_W-1:0] cnt [4];
  logic [COUNT_W-1:0] cnt_base [4];
  logic [COUNT_W-1:0] cnt_nxt [4];
  logic [COUNT_W-1:0] best;
  overlay_pixel_classify u_cls (
    .r   (bus.pix_r),
    .g   (bus.pix_g),
    .b   (bus.pix_b),
    .cls (pix_cls),
    .gray(pix_gray)
  );
  assign take = bus.pix_valid && (bus.pix_sof || state == ST_ACTIVE);
  always_ff @(posedge clk) state <= !rst_n ? ST_IDLE : state_nxt;
  always_comb state_nxt = take ? (bus.pix_eof ? ST_IDLE : ST_ACTIVE) : state;
  always_comb begin
    sync_nxt = bus.pix_valid && bus.pix_sof && state == ST_ACTIVE;
    load_nxt = take && bus.pix_eof;
  end
  always_ff @(posedge clk) begin
    load_pend    <= rst_n && load_nxt;
    bus.err_sync <= rst_n && sync_nxt;
  end
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_base[i] = bus.pix_sof ? '0 : cnt[i];
      cnt_nxt[i]  = (pix_cls == 3'(i) && cnt_base[i] != '1) ? cnt_base[i] + COUNT_W'(1) : cnt_base[i];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      cnt[i] <= !rst_n ? '0 : take ? cnt_nxt[i] : cnt[i];
  end
  // strict compare keeps the lowest index on ties and leaves CLS_BG when all counts are zero
  always_comb begin
    dom  = CLS_BG;
    best = '0;
    for (int i = 0; i < 4; i++) begin
      if (cnt[i] > best) begin
        best = cnt[i];
        dom  = cls_t'(3'(i));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rep_valid   <= 1'b0;
      bus.rep_cnt0    <= '0;
      bus.rep_cnt1    <= '0;
      bus.rep_cnt2    <= '0;
      bus.rep_cnt3    <= '0;
      bus.rep_dom     <= CLS_BG;
      bus.err_overrun <= 1'b0;
    end else begin
      if (load_pend && (!bus.rep_valid || bus.rep_ready)) begin
        bus.rep_valid <= 1'b1;
        bus.rep_cnt0  <= cnt[0];
        bus.rep_cnt1  <= cnt[1];
        bus.rep_cnt2  <= cnt[2];
        bus.rep_cnt3  <= cnt[3];
        bus.rep_dom   <= dom;
      end else if (bus.rep_valid && bus.rep_ready) begin
        bus.rep_valid <= 1'b0;
      end
      if (load_pend && bus.rep_valid && !bus.rep_ready) bus.err_overrun <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    bus.cls_valid <= rst_n && bus.pix_valid;
    bus.cls_out   <= !rst_n ? CLS_BG : bus.pix_valid ? pix_cls : bus.cls_out;
  end
`ifdef OVERLAY_DECODER_GRAY_EN
  always_ff @(posedge clk) bus.gray_out <= !rst_n ? 8'h00 : bus.pix_valid ? pix_gray : bus.gray_out;
`else
  logic unused_gray;
  assign unused_gray  = ^pix_gray;
  assign bus.gray_out = 8'h00;
`endif
endmodule

// File: tb/tb_overlay_decoder.sv
// tb_overlay_decoder: scoreboard bench for overlay_decoder (pixel and summary queues checked as the DUT produces output)
module tb_overlay_decoder;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  typedef struct {int cls; int gray;} px_t;
  typedef struct {int c0; int c1; int c2; int c3; int dom;} rep_t;
  logic clk;
  logic rst_n;
  int n_tests;
  int n_fail;
  bit mon_rep;
  px_t pix_q[$];
  rep_t rep_q[$];
  int m_cnt[4];
  bit m_act;
  logic [23:0] fr[$];
  overlay_decoder_if #(.COUNT_W(CW)) bus();
  overlay_decoder #(.COUNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int ref_cls(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if (r == 8'hFF && g == 8'hFF && b == 8'h00) return 0;
    if (r == 8'h00 && g == 8'hFF && b == 8'h00) return 1;
    if (r == 8'h00 && g == 8'h00 && b == 8'hFF) return 2;
    if (r == 8'hFF && g == 8'h00 && b == 8'h00) return 3;
    if (r == g && g == b && r >= 8'hC0) return 4;
    return 5;
  endfunction
  function automatic int ref_gray(input int c, input logic [7:0] r);
    int g;
    g = (c == 4) ? int'({r[5:0], 2'b00}) : 0;
`ifndef OVERLAY_DECODER_GRAY_EN
    g = 0;
`endif
    return g;
  endfunction
  task automatic send(input logic [23:0] px, input logic sof, input logic eof);
    int c;
    int d;
    int best;
    c = ref_cls(px[23:16], px[15:8], px[7:0]);
    bus.pix_valid = 1'b1;
    bus.pix_sof = sof;
    bus.pix_eof = eof;
    {bus.pix_r, bus.pix_g, bus.pix_b} = px;
    pix_q.push_back('{c, ref_gray(c, px[23:16])});
    if (sof) begin
      m_cnt = '{0, 0, 0, 0};
      m_act = 1'b1;
    end
    if (m_act) begin
      if (c < 4 && m_cnt[c] < MAXC) m_cnt[c]++;
      if (eof) begin
        d = 4;
        best = 0;
        for (int i = 0; i < 4; i++) if (m_cnt[i] > best) begin best = m_cnt[i]; d = i; end
        rep_q.push_back('{m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], d});
        m_act = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof = 1'b0;
    bus.pix_eof = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic run_frame();
    for (int i = 0; i < fr.size(); i++) send(fr[i], i == 0, i == fr.size() - 1);
  endtask
  task automatic wait_rep();
    int n;
    n = 0;
    while (rep_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("rep_drain", rep_q.size(), 0);
  endtask
  task automatic do_reset();
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cls_valid", bus.cls_valid, 0);
    chk("rst_cls_out", bus.cls_out, 4);
    chk("rst_gray", bus.gray_out, 0);
    chk("rst_rep_valid", bus.rep_valid, 0);
    chk("rst_cnt0", bus.rep_cnt0, 0);
    chk("rst_cnt1", bus.rep_cnt1, 0);
    chk("rst_cnt2", bus.rep_cnt2, 0);
    chk("rst_cnt3", bus.rep_cnt3, 0);
    chk("rst_dom", bus.rep_dom, 4);
    chk("rst_err_sync", bus.err_sync, 0);
    chk("rst_err_overrun", bus.err_overrun, 0);
    pix_q.delete();
    rep_q.delete();
    m_act = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    px_t p;
    rep_t r;
    if (rst_n) begin
      if (bus.cls_valid) begin
        chk("pix_q_nonempty", pix_q.size() != 0, 1);
        if (pix_q.size() != 0) begin
          p = pix_q.pop_front();
          chk("cls", bus.cls_out, p.cls);
          chk("gray", bus.gray_out, p.gray);
        end
      end
      if (mon_rep && bus.rep_valid && bus.rep_ready) begin
        chk("rep_q_nonempty", rep_q.size() != 0, 1);
        if (rep_q.size() != 0) begin
          r = rep_q.pop_front();
          chk("rep_cnt0", bus.rep_cnt0, r.c0);
          chk("rep_cnt1", bus.rep_cnt1, r.c1);
          chk("rep_cnt2", bus.rep_cnt2, r.c2);
          chk("rep_cnt3", bus.rep_cnt3, r.c3);
          chk("rep_dom", bus.rep_dom, r.dom);
        end
      end
    end
  end
  initial begin
    n_tests = 0;
    n_fail = 0;
    mon_rep = 1'b1;
    m_act = 1'b0;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_sof = 1'b0;
    bus.pix_eof = 1'b0;
    bus.pix_r = 8'h00;
    bus.pix_g = 8'h00;
    bus.pix_b = 8'h00;
    bus.rep_ready = 1'b1;
    do_reset();
    // pixel decoding while IDLE: nothing is counted, so no summary may appear
    send(24'hFFFF00, 0, 0);
    send(24'h0000FF, 0, 0);
    send(24'hE5E5E5, 0, 0);
    send(24'h123456, 0, 0);
    send(24'hFFFFFF, 0, 0);
    send(24'h00FF00, 0, 0);
    send(24'hFF0000, 0, 0);
    send(24'hC0C0C1, 0, 0);
    send(24'h3F3F3F, 0, 1);
    idle(4);
    chk("idle_no_rep", bus.rep_valid, 0);
    // 10-pixel frame: 3 DOT, 5 CROSS, 2 BG, summary latency
    fr = '{24'hFFFF00, 24'hFF0000, 24'hC8C8C8, 24'hFFFF00, 24'hFF0000,
           24'hFF0000, 24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'hFF0000};
    run_frame();
    @(negedge clk);
    chk("rep_lat_n", bus.rep_valid, 0);
    @(negedge clk);
    chk("rep_lat_n1", bus.rep_valid, 1);
    wait_rep();
    // tie between CIRCLE and X, then all-BG frame
    fr = '{24'hC4C4C4, 24'h00FF00, 24'h0000FF, 24'hD0D0D0, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
    run_frame();
    wait_rep();
    fr = '{24'hE0E0E0, 24'hC0C0C0, 24'hFFFFFF};
    run_frame();
    wait_rep();
    // restart with sof on pixel 4 of an active frame
    send(24'hFFFF00, 1, 0);
    @(negedge clk);
    chk("sync_from_idle", bus.err_sync, 0);
    send(24'h0000FF, 0, 0);
    send(24'h0000FF, 0, 0);
    send(24'h00FF00, 1, 0);
    @(negedge clk);
    chk("sync_pulse", bus.err_sync, 1);
    @(negedge clk);
    chk("sync_clear", bus.err_sync, 0);
    send(24'hFF0000, 0, 0);
    send(24'hFF0000, 0, 1);
    wait_rep();
    // overrun: second one-pixel frame dropped while first is held
    mon_rep = 1'b0;
    bus.rep_ready = 1'b0;
    send(24'hFFFF00, 1, 1);
    idle(3);
    chk("ovr_first_valid", bus.rep_valid, 1);
    chk("ovr_first_cnt0", bus.rep_cnt0, 1);
    chk("ovr_first_flag", bus.err_overrun, 0);
    send(24'hFF0000, 1, 1);
    idle(3);
    chk("ovr_held_cnt0", bus.rep_cnt0, 1);
    chk("ovr_held_cnt3", bus.rep_cnt3, 0);
    chk("ovr_held_dom", bus.rep_dom, 0);
    chk("ovr_flag", bus.err_overrun, 1);
    do_reset();
    bus.rep_ready = 1'b0;
    send(24'hFFFF00, 1, 1);
    idle(3);
    chk("swap_first_cnt0", bus.rep_cnt0, 1);
    send(24'hFF0000, 1, 1);
    bus.rep_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rep_ready = 1'b0;
    @(negedge clk);
    chk("swap_valid", bus.rep_valid, 1);
    chk("swap_cnt0", bus.rep_cnt0, 0);
    chk("swap_cnt3", bus.rep_cnt3, 1);
    chk("swap_dom", bus.rep_dom, 3);
    chk("swap_no_overrun", bus.err_overrun, 0);
    rep_q.delete();
    bus.rep_ready = 1'b1;
    idle(2);
    chk("swap_consumed", bus.rep_valid, 0);
    mon_rep = 1'b1;
    // saturation: 20 DOT pixels into 4-bit counters
    fr.delete();
    repeat (20) fr.push_back(24'hFFFF00);
    run_frame();
    wait_rep();
    // reset mid-frame discards the partial frame
    send(24'h0000FF, 1, 0);
    send(24'h0000FF, 0, 0);
    send(24'hFFFF00, 0, 0);
    do_reset();
    idle(5);
    chk("mid_rst_no_rep", bus.rep_valid, 0);
    chk("pix_q_drained", pix_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/overlay_decoder.md
OVERLAY_DECODER -- requirements
Module: overlay_decoder

Interface
REQ-001 Parameter COUNT_W, default 20: width of the per-class frame pixel counters.
REQ-002 Port clk  input  1: the single clock; all logic is on its rising edge.
REQ-003 Port rst_n  input  1: reset, synchronous and active-low.
REQ-004 Port pix_valid  input  1: input pixel qualifier; the stream has no backpressure.
REQ-005 Port pix_sof  input  1: first pixel of a frame; meaningful only when pix_valid=1.
REQ-006 Port pix_eof  input  1: last pixel of a frame; meaningful only when pix_valid=1.
REQ-007 Ports pix_r, pix_g, pix_b  input  8 each: overlay-coloured RGB pixel.
REQ-008 Port cls_valid  output  1: per-pixel result valid.
REQ-009 Port cls_out  output  3: per-pixel class code (cls_t).
REQ-010 Port gray_out  output  8: recovered luminance.
REQ-011 Ports rep_valid (output 1) and rep_ready (input 1): frame-summary handshake.
REQ-012 Ports rep_cnt0..rep_cnt3  output  COUNT_W each: per-symbol pixel counts.
REQ-013 Ports rep_dom (output 3: dominant class), err_sync (output 1: pulse on frame restart) and err_overrun (output 1: sticky).

Function
REQ-014 Decoding SHALL be exact: FF/FF/00=CLS_DOT(0); 00/FF/00=CLS_CIRCLE(1); 00/00/FF=CLS_X(2); FF/00/00=CLS_CROSS(3).
REQ-015 r==g==b with r[7:6]=2'b11 SHALL be CLS_BG(4), with gray_out={r[5:0],2'b00}; any other pixel SHALL be CLS_OTHER(5), with gray_out=0.
REQ-016 Symbol classes SHALL take priority over CLS_BG; FF/FF/FF therefore decodes as CLS_BG.
REQ-017 Per-pixel latency SHALL be 1 cycle: cls_valid, cls_out and gray_out are registered from pix_valid.
REQ-018 While cls_valid=0, cls_out and gray_out SHALL hold their last values.
REQ-019 The FSM SHALL have two states, IDLE and ACTIVE.
REQ-020 IDLE: valid pixels without pix_sof SHALL NOT be counted; pix_valid&pix_sof SHALL clear the counters, count that pixel and enter ACTIVE.
REQ-021 ACTIVE: every valid pixel SHALL increment its class counter; only classes 0-3 are counted.
REQ-022 ACTIVE: pix_sof SHALL restart the counters with that pixel and pulse err_sync for one cycle.
REQ-023 pix_sof&pix_eof on the same pixel SHALL be a one-pixel frame.
REQ-024 On an eof pixel at edge N, the FSM SHALL return to IDLE; the summary SHALL load at edge N+1, with rep_valid=1 after edge N+1.
REQ-025 Counters SHALL saturate at 2^COUNT_W-1 and never wrap.
REQ-026 rep_dom SHALL be the class 0-3 with the maximum count, ties going to the lowest index; if all counts are 0, rep_dom SHALL be CLS_BG.
REQ-027 The summary registers SHALL be independent of the counters, so the next frame may accumulate while a summary is pending.
REQ-028 rep_valid&rep_ready at an edge SHALL consume the summary; rep_* values SHALL stay stable while rep_valid=1 and rep_ready=0.
REQ-029 If a load occurs while rep_valid=1 and rep_ready=0, the new summary SHALL be dropped, the old one retained, and err_overrun set.
REQ-030 A load coinciding with consumption SHALL take the new summary, with no overrun.

Reset
REQ-031 rst_n=0 at an edge SHALL force: FSM=IDLE, counters=0, cls_valid=0, cls_out=CLS_BG, gray_out=0.
REQ-032 Reset SHALL also force: rep_valid=0, rep_cnt*=0, rep_dom=CLS_BG, err_sync=0, err_overrun=0.
REQ-033 Reset mid-frame SHALL discard the partial frame, and a pending summary SHALL be lost.

Configuration
REQ-034 With OVERLAY_DECODER_GRAY_EN defined, gray_out SHALL behave per REQ-015.
REQ-035 Without OVERLAY_DECODER_GRAY_EN, gray_out SHALL be constant 0 with no gray register; all other behaviour is unchanged.

Structure
REQ-036 Package npu_pkg SHALL hold cls_t (3-bit enum, 0-5), the colour constants for DOT, CIRCLE, X and CROSS, and BG_PREFIX=2'b11.
REQ-037 Pixel classification SHALL be a combinational sub-module, overlay_pixel_classify (rgb in; cls and gray out).

Verification
REQ-038 Scenario: pixels FF/FF/00, 00/00/FF, E5/E5/E5, 12/34/56 -> next cycles: cls 0,2,4,5 and gray_out 0,0,94,0.
REQ-039 Scenario: frame of 10 pixels (3 DOT, 5 CROSS, 2 BG), rep_ready=1 -> rep_valid 2 cycles after eof; cnt0=3, cnt3=5, cnt1=cnt2=0, rep_dom=3.
REQ-040 Scenario: frame with 2 CIRCLE and 2 X, all else BG -> rep_dom=1; frame of all BG -> rep_dom=4.
REQ-041 Scenario: sof at pixel 4 of an ACTIVE frame -> err_sync pulses for 1 cycle; the summary counts only pixels from the second sof.
REQ-042 Scenario: two 1-pixel frames with rep_ready=0 -> first summary held, err_overrun=1; repeat with rep_ready=1 at the second load -> second summary taken, err_overrun=0.
REQ-043 Scenario: COUNT_W=4, 20 DOT pixels -> cnt0=15; rst_n=0 mid-frame -> all outputs at reset values the next cycle, and no summary is produced.
